// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and arbiter state encoding for the
// register-file writeback scheduler.
package regfile_wb_scheduler_pkg;

  localparam int RF_DATA_W   = 8;
  localparam int RF_ADDR_W   = 3;
  localparam int RF_NUM_REGS = 8;

  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_LD  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_wb_scheduler_arb.sv
// Two-input round-robin arbiter with a registered
// last-winner state; port 0 wins the first conflict.
module rr_arbiter2
  import regfile_wb_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  arb_state_e last_q, last_d;

  always_comb begin
    gnt0   = req0 & (~req1 | (last_q == LAST_LD));
    gnt1   = req1 & ~gnt0;
    last_d = last_q;
    if (gnt0)      last_d = LAST_ALU;
    else if (gnt1) last_d = LAST_LD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= LAST_LD;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback port scheduler: ALU/load arbitration, busy
// scoreboard for RAW/WAW stalls, registered write port.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ready,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              hazard,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data
);

  logic                gnt_alu, gnt_ld, accept;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst),
    .req0  (alu_valid),
    .req1  (ld_valid),
    .gnt0  (gnt_alu),
    .gnt1  (gnt_ld)
  );

  always_comb begin
    alu_ready = gnt_alu;
    ld_ready  = gnt_ld;
    accept    = gnt_alu | gnt_ld;
    win_addr  = gnt_alu ? alu_addr : ld_addr;
    win_data  = gnt_alu ? alu_data : ld_data;
    rsv_ready = rsv_valid & ~busy_q[rsv_addr];
    hazard    = busy_q[chk_addr1] | busy_q[chk_addr2];
    // Set is applied after clear so a same-address reserve wins.
    busy_d = busy_q;
    if (accept)    busy_d[win_addr] = 1'b0;
    if (rsv_ready) busy_d[rsv_addr] = 1'b1;
    we_d    = accept;
    waddr_d = accept ? win_addr : waddr_q;
    wdata_d = accept ? win_data : wdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      busy_q  <= busy_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy_vec        = busy_q;
  assign rf_write_enable = we_q;
  assign rf_write_addr   = waddr_q;
  assign rf_write_data   = wdata_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scenario tasks plus a randomized run against a
// behavioural writeback/scoreboard model.
module tb_regfile_wb_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_valid, ld_valid, rsv_valid;
  logic [2:0] alu_addr, ld_addr, rsv_addr;
  logic [7:0] alu_data, ld_data;
  logic [2:0] chk_addr1, chk_addr2;
  logic       alu_ready, ld_ready, rsv_ready, hazard;
  logic [7:0] busy_vec;
  logic       rf_write_enable;
  logic [2:0] rf_write_addr;
  logic [7:0] rf_write_data;

  int vecs = 0;
  int errs = 0;

  regfile_wb_scheduler dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_ready(ld_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rsv_ready(rsv_ready),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .hazard(hazard), .busy_vec(busy_vec),
    .rf_write_enable(rf_write_enable),
    .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data)
  );

  always #5 clk = ~clk;

  task automatic idle();
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    ld_valid = 0;  ld_addr = 0;  ld_data = 0;
    rsv_valid = 0; rsv_addr = 0;
    chk_addr1 = 0; chk_addr2 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    step();
    rst = 1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if ({busy_vec, rf_write_enable, rf_write_addr,
         rf_write_data} !== 20'h0) begin
      errs++;
      $display("FAIL reset_state busy=%h we=%b a=%0d d=%h need 0",
               busy_vec, rf_write_enable, rf_write_addr, rf_write_data);
    end
    vecs++;
    if ({alu_ready, ld_ready, rsv_ready, hazard} !== 4'b0) begin
      errs++;
      $display("FAIL reset_ready got %b need 0000",
               {alu_ready, ld_ready, rsv_ready, hazard});
    end
  endtask

  task automatic test_reserve_hazard();
    rsv_valid = 1; rsv_addr = 2; chk_addr1 = 2; #1;
    vecs++;
    if ({rsv_ready, hazard} !== 2'b10) begin
      errs++;
      $display("FAIL rsv2_pre got %b need 10", {rsv_ready, hazard});
    end
    step();
    rsv_valid = 0; #1;
    vecs++;
    if (busy_vec !== 8'h04 || hazard !== 1'b1) begin
      errs++;
      $display("FAIL rsv2_busy busy=%h haz=%b need 04/1", busy_vec, hazard);
    end
  endtask

  task automatic test_alu_alone();
    alu_valid = 1; alu_addr = 2; alu_data = 8'hAA; #1;
    vecs++;
    if ({alu_ready, ld_ready} !== 2'b10) begin
      errs++;
      $display("FAIL alu_alone_rdy got %b need 10", {alu_ready, ld_ready});
    end
    step();
    alu_valid = 0; #1;
    vecs++;
    if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 3'd2, 8'hAA}
        || busy_vec !== 8'h00 || hazard !== 1'b0) begin
      errs++;
      $display("FAIL alu_alone_wr we=%b a=%0d d=%h busy=%h haz=%b need 1/2/aa/00/0",
               rf_write_enable, rf_write_addr, rf_write_data, busy_vec, hazard);
    end
    step();
    vecs++;
    if (rf_write_enable !== 1'b0 || rf_write_data !== 8'hAA) begin
      errs++;
      $display("FAIL alu_alone_hold we=%b d=%h need 0/aa",
               rf_write_enable, rf_write_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    alu_valid = 1; alu_addr = 4; alu_data = 8'hCC;
    ld_valid = 1;  ld_addr = 5;  ld_data = 8'h33;
    for (int i = 0; i < 4; i++) begin
      logic alu_turn;
      alu_turn = (i % 2 == 0);
      #1;
      vecs++;
      if ({alu_ready, ld_ready} !== {alu_turn, ~alu_turn}) begin
        errs++;
        $display("FAIL alternate_%0d got %b need %b", i,
                 {alu_ready, ld_ready}, {alu_turn, ~alu_turn});
      end
      step();
      vecs++;
      if ({rf_write_enable, rf_write_addr, rf_write_data} !==
          (alu_turn ? {1'b1, 3'd4, 8'hCC} : {1'b1, 3'd5, 8'h33})) begin
        errs++;
        $display("FAIL alternate_wr_%0d we=%b a=%0d d=%h", i,
                 rf_write_enable, rf_write_addr, rf_write_data);
      end
    end
    idle();
  endtask

  task automatic test_waw();
    rsv_valid = 1; rsv_addr = 3; #1;
    vecs++;
    if (rsv_ready !== 1'b1) begin
      errs++;
      $display("FAIL waw_first got %b need 1", rsv_ready);
    end
    step(); #1;
    vecs++;
    if (rsv_ready !== 1'b0) begin
      errs++;
      $display("FAIL waw_second got %b need 0", rsv_ready);
    end
    step();
    alu_valid = 1; alu_addr = 3; alu_data = 8'h77; #1;
    vecs++;
    if ({alu_ready, rsv_ready} !== 2'b10 || busy_vec !== 8'h08) begin
      errs++;
      $display("FAIL waw_wb_pre rdy=%b busy=%h need 10/08",
               {alu_ready, rsv_ready}, busy_vec);
    end
    step();
    alu_valid = 0; #1;
    vecs++;
    if (busy_vec !== 8'h00 || rsv_ready !== 1'b1) begin
      errs++;
      $display("FAIL waw_cleared busy=%h rsv=%b need 00/1", busy_vec, rsv_ready);
    end
    step();
    rsv_valid = 0; #1;
    vecs++;
    if (busy_vec !== 8'h08) begin
      errs++;
      $display("FAIL waw_reset3 busy=%h need 08", busy_vec);
    end
  endtask

  task automatic test_set_wins();
    ld_valid = 1; ld_addr = 1; ld_data = 8'h11;
    rsv_valid = 1; rsv_addr = 1; #1;
    vecs++;
    if ({ld_ready, rsv_ready} !== 2'b11) begin
      errs++;
      $display("FAIL setwin_pre got %b need 11", {ld_ready, rsv_ready});
    end
    step();
    idle(); #1;
    vecs++;
    if (busy_vec !== 8'h0A ||
        {rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 3'd1, 8'h11}) begin
      errs++;
      $display("FAIL setwin_post busy=%h we=%b a=%0d d=%h need 0a/1/1/11",
               busy_vec, rf_write_enable, rf_write_addr, rf_write_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsv_valid = 1; rsv_addr = 4; step();
    rsv_addr = 5; step();
    rsv_valid = 0;
    ld_valid = 1; ld_addr = 6; ld_data = 8'h5A; step();
    ld_valid = 0; #1;
    vecs++;
    if (busy_vec !== 8'h30 || rf_write_enable !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_setup busy=%h we=%b need 30/1",
               busy_vec, rf_write_enable);
    end
    #1 rst = 0; #1;
    vecs++;
    if (busy_vec !== 8'h00 || rf_write_enable !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_async busy=%h we=%b need 00/0",
               busy_vec, rf_write_enable);
    end
    step();
    rst = 1;
    alu_valid = 1; ld_valid = 1; #1;
    vecs++;
    if ({alu_ready, ld_ready} !== 2'b10) begin
      errs++;
      $display("FAIL rstmid_first got %b need 10", {alu_ready, ld_ready});
    end
    step();
    idle();
  endtask

  task automatic test_random();
    bit         m_busy[8];
    bit         m_alu_last;
    bit         m_we;
    bit   [2:0] m_a;
    bit   [7:0] m_d;
    bit         a_pend, l_pend;
    logic       e_alu, e_ld, e_rsv, e_haz;
    logic [7:0] e_busy;
    do_reset();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_alu_last = 0; m_we = 0; m_a = 0; m_d = 0;
    a_pend = 0; l_pend = 0;
    for (int c = 0; c < 400; c++) begin
      if (!a_pend) begin
        alu_valid = ($urandom % 2) == 1;
        alu_addr  = 3'($urandom);
        alu_data  = 8'($urandom);
      end
      if (!l_pend) begin
        ld_valid = ($urandom % 2) == 1;
        ld_addr  = 3'($urandom);
        ld_data  = 8'($urandom);
      end
      rsv_valid = ($urandom % 3) != 0;
      rsv_addr  = 3'($urandom);
      chk_addr1 = 3'($urandom);
      chk_addr2 = 3'($urandom);
      #1;
      if (alu_valid && ld_valid) begin
        e_alu = !m_alu_last; e_ld = m_alu_last;
      end else begin
        e_alu = alu_valid; e_ld = ld_valid;
      end
      e_rsv = rsv_valid && !m_busy[rsv_addr];
      e_haz = m_busy[chk_addr1] || m_busy[chk_addr2];
      vecs++;
      if ({alu_ready, ld_ready, rsv_ready, hazard} !==
          {e_alu, e_ld, e_rsv, e_haz}) begin
        errs++;
        $display("FAIL rand_comb c=%0d got %b need %b", c,
                 {alu_ready, ld_ready, rsv_ready, hazard},
                 {e_alu, e_ld, e_rsv, e_haz});
      end
      m_we = e_alu || e_ld;
      if (e_alu) begin
        m_a = alu_addr; m_d = alu_data; m_alu_last = 1;
      end else if (e_ld) begin
        m_a = ld_addr; m_d = ld_data; m_alu_last = 0;
      end
      if (m_we)  m_busy[m_a] = 0;
      if (e_rsv) m_busy[rsv_addr] = 1;
      a_pend = alu_valid && !e_alu;
      l_pend = ld_valid && !e_ld;
      step();
      foreach (m_busy[i]) e_busy[i] = m_busy[i];
      vecs++;
      if (busy_vec !== e_busy ||
          {rf_write_enable, rf_write_addr, rf_write_data} !== {m_we, m_a, m_d}) begin
        errs++;
        $display("FAIL rand_reg c=%0d busy=%h/%h we=%b/%b a=%0d/%0d d=%h/%h",
                 c, busy_vec, e_busy, rf_write_enable, m_we,
                 rf_write_addr, m_a, rf_write_data, m_d);
      end
    end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    #2;
    test_reset();
    test_reserve_hazard();
    test_alu_alone();
    test_back_to_back();
    test_waw();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
